// File: rtl/rv_trace_packer_if.sv
// Write-back retire bus and 32-bit trace word stream used by rv_trace_packer.
// The core side drives the retire bus; the packer drives the stream.
interface rv_trace_wb_if;
    logic        valid;
    logic [29:0] pc;
    logic [31:0] instr;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] reg_data;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    modport master (output valid, pc, instr, reg_write, rd, reg_data,
                    mem_read, mem_write, mem_sel, mem_addr, mem_data);
    modport slave  (input  valid, pc, instr, reg_write, rd, reg_data,
                    mem_read, mem_write, mem_sel, mem_addr, mem_data);
endinterface

interface rv_trace_stream_if;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        ready;

    modport master (output valid, data, last, input  ready);
    modport slave  (input  valid, data, last, output ready);
endinterface

// File: rtl/rv_trace_packer.sv
// Retired-instruction trace capture: one packed record per retire into a small FIFO,
// serialized as 32-bit words on a valid/ready stream. The core is never stalled.
//
// state   | meaning
// S_IDLE  | no record in flight, stream idle
// S_HDR   | header word presented
// S_PC    | {pc,2'b00} presented
// S_INSTR | opcode presented
// S_RDATA | rd write data presented
// S_MADDR | memory access address presented
// S_MDATA | load/store data presented
module rv_trace_packer #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 12
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_trace_en,
    rv_trace_wb_if.slave             wb,
    rv_trace_stream_if.master        trc,
    output logic [15:0]              o_drop_cnt,
    output logic [$clog2(DEPTH):0]   o_fifo_level
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    typedef struct packed {
        logic [31:0] hdr;
        logic [29:0] pc;
        logic [31:0] instr;
        logic [31:0] rdata;
        logic [31:0] maddr;
        logic [31:0] mdata;
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PC, S_INSTR, S_RDATA, S_MADDR, S_MDATA
    } state_t;

    rec_t             fifo_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    state_t           state, nxt_state;
    rec_t             cur;
    logic             lost;
    logic [SEQ_W-1:0] seq;

    logic push_req, push, pop, full, empty, fire, has_mem;
    logic [2:0]  wcnt;
    logic [31:0] new_hdr;
    rec_t        new_rec;

    // Optional words follow the header flags: RDATA when rd written, MADDR/MDATA for any mem op.
    function automatic state_t next_of(state_t s, logic [31:0] hdr);
        logic rw, mem;
        rw  = hdr[24];
        mem = hdr[23] | hdr[22];
        case (s)
            S_HDR:   return S_PC;
            S_PC:    return S_INSTR;
            S_INSTR: return rw ? S_RDATA : (mem ? S_MADDR : S_IDLE);
            S_RDATA: return mem ? S_MADDR : S_IDLE;
            S_MADDR: return S_MDATA;
            default: return S_IDLE;
        endcase
    endfunction

    function automatic logic [31:0] word_of(state_t s, rec_t r);
        case (s)
            S_HDR:   return r.hdr;
            S_PC:    return {r.pc, 2'b00};
            S_INSTR: return r.instr;
            S_RDATA: return r.rdata;
            S_MADDR: return r.maddr;
            S_MDATA: return r.mdata;
            default: return 32'd0;
        endcase
    endfunction

    assign push_req  = wb.valid & i_trace_en;
    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign fire      = trc.valid & trc.ready;
    assign pop       = !empty & ((state == S_IDLE) | (fire & trc.last));
    assign push      = push_req & (!full | pop);
    assign has_mem   = wb.mem_read | wb.mem_write;
    assign wcnt      = 3'd3 + {2'b00, wb.reg_write} + {1'b0, has_mem, 1'b0};
    assign new_hdr   = {4'hA, wcnt, wb.reg_write, wb.mem_write, wb.mem_read, lost,
                        wb.reg_write ? wb.rd : 5'd0, has_mem ? wb.mem_sel : 4'd0, seq};
    assign new_rec   = {new_hdr, wb.pc, wb.instr, wb.reg_data, wb.mem_addr, wb.mem_data};
    assign nxt_state = next_of(state, cur.hdr);
    assign o_fifo_level = level;

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr] <= new_rec;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            cur        <= '0;
            trc.valid  <= 1'b0;
            trc.data   <= 32'd0;
            trc.last   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            lost       <= 1'b0;
            seq        <= '0;
            o_drop_cnt <= 16'd0;
        end else begin
            if (push_req) seq <= seq + 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                lost   <= 1'b0;
            end else if (push_req) begin
                lost <= 1'b1;
                if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);

            // A pop either starts from idle or chains straight off an accepted last word.
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                cur       <= fifo_mem[rd_ptr];
                state     <= S_HDR;
                trc.valid <= 1'b1;
                trc.data  <= fifo_mem[rd_ptr].hdr;
                trc.last  <= 1'b0;
            end else if (fire) begin
                state     <= nxt_state;
                trc.valid <= (nxt_state != S_IDLE);
                trc.data  <= word_of(nxt_state, cur);
                trc.last  <= (nxt_state != S_IDLE) && (next_of(nxt_state, cur.hdr) == S_IDLE);
            end
        end
    end
endmodule

// File: tb/tb_rv_trace_packer.sv
// Randomized bench for rv_trace_packer against a queue-based record/word model,
// plus a few directed header, overflow and reset scenarios.
module tb_rv_trace_packer;
    localparam int DEPTH = 8;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_trace_en;
    logic [15:0] o_drop_cnt;
    logic [3:0]  o_fifo_level;

    rv_trace_wb_if     wb();
    rv_trace_stream_if trc();

    rv_trace_packer #(.DEPTH(DEPTH), .SEQ_W(12)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_trace_en(i_trace_en),
        .wb(wb), .trc(trc), .o_drop_cnt(o_drop_cnt), .o_fifo_level(o_fifo_level)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: stored records as word lists, the in-flight record as a word queue.
    int unsigned m_len[$];
    logic [31:0] m_fifo[$];
    logic [31:0] m_cur[$];
    int          m_seq;
    bit          m_lost;
    int          m_drop;

    task automatic model_reset();
        m_len.delete(); m_fifo.delete(); m_cur.delete();
        m_seq = 0; m_lost = 0; m_drop = 0;
    endtask

    task automatic model_step();
        bit mvalid, fire, pop, push_req, store, mem;
        int unsigned n;
        logic [31:0] hdr;
        mvalid   = (m_cur.size() > 0);
        fire     = mvalid && trc.ready;
        pop      = (m_len.size() > 0) && (!mvalid || (fire && m_cur.size() == 1));
        push_req = wb.valid && i_trace_en;
        store    = push_req && (m_len.size() < DEPTH || pop);
        if (fire) void'(m_cur.pop_front());
        if (pop) begin
            n = m_len.pop_front();
            repeat (n) m_cur.push_back(m_fifo.pop_front());
        end
        if (store) begin
            mem = wb.mem_read || wb.mem_write;
            n = 3 + (wb.reg_write ? 1 : 0) + (mem ? 2 : 0);
            hdr = 32'hA000_0000 + (32'(n) << 25) + (32'(wb.reg_write) << 24)
                + (32'(wb.mem_write) << 23) + (32'(wb.mem_read) << 22) + (32'(m_lost) << 21)
                + (wb.reg_write ? 32'(wb.rd) << 16 : 32'd0)
                + (mem ? 32'(wb.mem_sel) << 12 : 32'd0) + 32'(m_seq % 4096);
            m_fifo.push_back(hdr);
            m_fifo.push_back(32'(wb.pc) * 4);
            m_fifo.push_back(wb.instr);
            if (wb.reg_write) m_fifo.push_back(wb.reg_data);
            if (mem) begin
                m_fifo.push_back(wb.mem_addr);
                m_fifo.push_back(wb.mem_data);
            end
            m_len.push_back(n);
            m_lost = 0;
        end else if (push_req) begin
            m_lost = 1;
            if (m_drop < 16'hFFFF) m_drop++;
        end
        if (push_req) m_seq = (m_seq + 1) % 4096;
    endtask

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) model_reset();
        else model_step();
    end

    always @(negedge i_clk) begin
        if (i_reset_n) begin
            chk("valid", 32'(trc.valid), 32'(m_cur.size() > 0));
            if (m_cur.size() > 0) begin
                chk("data", trc.data, m_cur[0]);
                chk("last", 32'(trc.last), 32'(m_cur.size() == 1));
            end
            chk("level", 32'(o_fifo_level), 32'(m_len.size()));
            chk("drops", 32'(o_drop_cnt), 32'(m_drop));
        end
    end

    task automatic drive_retire(input bit rw, input bit mr, input bit mw);
        wb.valid     = 1'b1;
        wb.pc        = 30'($urandom);
        wb.instr     = $urandom;
        wb.reg_write = rw;
        wb.rd        = 5'($urandom);
        wb.reg_data  = $urandom;
        wb.mem_read  = mr;
        wb.mem_write = mw;
        wb.mem_sel   = 4'($urandom);
        wb.mem_addr  = $urandom;
        wb.mem_data  = $urandom;
    endtask

    task automatic drive_addi();
        drive_retire(1'b1, 1'b0, 1'b0);
        wb.pc = 30'h40; wb.instr = 32'h0050_0093; wb.rd = 5'd1; wb.reg_data = 32'd5;
    endtask

    task automatic cycles_idle(input int n);
        wb.valid = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    initial begin
        i_reset_n = 1'b0; i_trace_en = 1'b1; trc.ready = 1'b1;
        drive_retire(1'b0, 1'b0, 1'b0);
        wb.valid = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_valid", 32'(trc.valid), 32'd0);
        chk("rst_level", 32'(o_fifo_level), 32'd0);
        chk("rst_drop", 32'(o_drop_cnt), 32'd0);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        // ADDI: header one edge after capture
        drive_addi();
        @(negedge i_clk);
        wb.valid = 1'b0;
        @(negedge i_clk);
        chk("addi_valid", 32'(trc.valid), 32'd1);
        chk("addi_hdr", trc.data, 32'hA901_0000);
        cycles_idle(6);

        // SW, seq 1
        drive_retire(1'b0, 1'b0, 1'b1);
        wb.pc = 30'h41; wb.mem_addr = 32'h2000; wb.mem_sel = 4'hF; wb.mem_data = 32'hDEAD_BEEF;
        @(negedge i_clk);
        wb.valid = 1'b0;
        @(negedge i_clk);
        chk("sw_hdr", trc.data, 32'hAA80_F001);
        cycles_idle(8);

        // overflow with sink stalled: one record in flight, eight stored, one dropped
        trc.ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_retire(1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge i_clk);
        end
        wb.valid = 1'b0;
        chk("ovf_level", 32'(o_fifo_level), 32'd8);
        chk("ovf_drop", 32'(o_drop_cnt), 32'd1);
        trc.ready = 1'b1;
        cycles_idle(60);
        drive_retire(1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        wb.valid = 1'b0;
        @(negedge i_clk);
        chk("lost_bit", 32'(trc.data[21]), 32'd1);
        chk("lost_seq", 32'(trc.data[11:0]), 32'd12);
        cycles_idle(5);

        // ready toggling over an LW+rd record
        drive_retire(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            wb.valid  = 1'b0;
            trc.ready = ~trc.ready;
        end
        trc.ready = 1'b1;
        cycles_idle(4);

        // capture disabled: retires ignored, seq holds
        i_trace_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_retire(1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge i_clk);
        end
        i_trace_en = 1'b1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 55) drive_retire(1'($urandom), 1'($urandom), 1'($urandom));
            else wb.valid = 1'b0;
            trc.ready  = ($urandom_range(99) < 65);
            i_trace_en = ($urandom_range(99) < 92);
            @(negedge i_clk);
        end
        trc.ready = 1'b1; i_trace_en = 1'b1;
        cycles_idle(60);

        // async reset while the third word of a six-word record is presented
        drive_retire(1'b1, 1'b1, 1'b1);
        @(negedge i_clk);
        wb.valid = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("mid_word3", trc.data, m_cur[0]);
        #2 i_reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(trc.valid), 32'd0);
        chk("arst_data", trc.data, 32'd0);
        chk("arst_last", 32'(trc.last), 32'd0);
        chk("arst_level", 32'(o_fifo_level), 32'd0);
        chk("arst_drop", 32'(o_drop_cnt), 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        drive_addi();
        @(negedge i_clk);
        wb.valid = 1'b0;
        @(negedge i_clk);
        chk("post_rst_hdr", trc.data, 32'hA901_0000);
        cycles_idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
